// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one iterative CORDIC engine between two
// requesters. One job is outstanding at a time. The FSM walks through the states
// IDLE -> ISSUE -> BUSY -> RESP. A job returns the engine result, or an error
// response when the engine does not finish within TIMEOUT busy cycles.
module cordic_arbiter #(
  // Busy cycles without eng_done before abort; meaningful range 20..255
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        req0_valid,
  input  logic [31:0] req0_angle,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_angle,
  output logic        req1_ready,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        eng_start,
  output logic [31:0] eng_dataa,
  output logic        eng_abort,
  input  logic [31:0] eng_result,
  input  logic        eng_done,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_grant;
  logic        r_last_grant;
  logic [7:0]  r_cnt;
  logic [31:0] r_dataa;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_win;
  logic        w_accept;
  logic        w_done_ok;
  logic        w_timeout;

  // Round-robin winner: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    w_win = 1'b0;
    if (req0_valid && req1_valid) begin
      w_win = ~r_last_grant;
    end else if (req1_valid) begin
      w_win = 1'b1;
    end
  end

  assign w_accept  = (r_state == StIdle) && (req0_valid || req1_valid);
  // r_cnt is 0 only in the first BUSY cycle, where the engine flag may still be stale
  assign w_done_ok = (r_state == StBusy) && (r_cnt != 8'd0) && eng_done;
  assign w_timeout = (r_state == StBusy) && !w_done_ok && (r_cnt == TimeoutCnt);

  // Next-state and handshake/engine control outputs
  always_comb begin
    w_state_next = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    eng_start    = 1'b0;
    eng_abort    = 1'b0;
    unique case (r_state)
      StIdle: begin
        req0_ready = req0_valid && !w_win;
        req1_ready = req1_valid && w_win;
        if (w_accept) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        eng_start    = 1'b1;
        w_state_next = StBusy;
      end
      StBusy: begin
        if (w_done_ok) begin
          w_state_next = StResp;
        end else if (w_timeout) begin
          eng_abort    = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        rsp0_valid = !r_grant;
        rsp1_valid = r_grant;
        if (r_grant ? rsp1_ready : rsp0_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, grant bookkeeping, timeout counter and captured data; frozen when clk_en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 8'd0;
      r_dataa      <= 32'd0;
      r_rsp_data   <= 32'd0;
      r_rsp_err    <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_dataa      <= w_win ? req1_angle : req0_angle;
        r_grant      <= w_win;
        r_last_grant <= w_win;
      end
      if (r_state == StIssue) begin
        r_cnt <= 8'd0;
      end else if (r_state == StBusy) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_done_ok) begin
        r_rsp_data <= eng_result;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= 32'd0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign eng_dataa = r_dataa;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter: a behavioural engine model, a round-robin reference
// model feeding a scoreboard queue, and a monitor that checks each response handshake.
module tb_cordic_arbiter;

  localparam int unsigned Timeout = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_angle, req1_angle;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        eng_start;
  logic [31:0] eng_dataa;
  logic        eng_abort;
  logic [31:0] eng_result;
  logic        eng_done;
  logic        busy;

  cordic_arbiter #(.TIMEOUT(Timeout)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .req0_valid (req0_valid),
    .req0_angle (req0_angle),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_angle (req1_angle),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_dataa  (eng_dataa),
    .eng_abort  (eng_abort),
    .eng_result (eng_result),
    .eng_done   (eng_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int t = 0;
  always @(posedge clk) t <= t + 1;

  // Stand-in for the engine's output word; angle 0 gives the CORDIC gain constant
  function automatic logic [31:0] eng_fn(input logic [31:0] a);
    return a ^ 32'h26DD3B6A;
  endfunction

  // Engine model: done rises 17 cycles after the start cycle and stays high until the
  // next start (a stale flag). e_hang suppresses done; done_force overrides the flag.
  logic        e_run, e_done, e_hang, done_force;
  int          e_cnt;
  logic [31:0] e_arg, e_res, force_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_run <= 1'b0; e_done <= 1'b0; e_cnt <= 0; e_arg <= '0; e_res <= '0;
    end else if (clk_en) begin
      if (eng_abort) begin
        e_run <= 1'b0; e_done <= 1'b0;
      end else if (eng_start) begin
        e_run <= 1'b1; e_done <= 1'b0; e_cnt <= 1; e_arg <= eng_dataa;
      end else if (e_run) begin
        if (e_cnt == 16 && !e_hang) begin
          e_done <= 1'b1; e_res <= eng_fn(e_arg); e_run <= 1'b0;
        end
        e_cnt <= e_cnt + 1;
      end
    end
  end

  assign eng_done   = e_done | done_force;
  assign eng_result = done_force ? force_res : e_res;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mdl_last = 1'b1;  // reference round-robin pointer
  int   mdl_mode = 0;     // 0: engine result, 1: timeout, 2: forced done value

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, t);
  endtask

  // Wait for an acceptance, check readies against the reference arbiter, push expectation
  task automatic accept(output int a_cyc);
    bit          ok;
    int          win;
    exp_t        e;
    logic [31:0] ang;
    ok    = 1'b0;
    a_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!reset && clk_en && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_seen", 32'd0, 32'd1);
      return;
    end
    if (req0_valid && req1_valid) win = mdl_last ? 0 : 1;
    else win = req1_valid ? 1 : 0;
    check("req0_ready", 32'(req0_ready), 32'(win == 0));
    check("req1_ready", 32'(req1_ready), 32'(win == 1));
    mdl_last = win[0];
    ang      = win[0] ? req1_angle : req0_angle;
    e.port   = win[0];
    case (mdl_mode)
      1:       begin e.data = 32'd0;     e.err = 1'b1; end
      2:       begin e.data = force_res; e.err = 1'b0; end
      default: begin e.data = eng_fn(ang); e.err = 1'b0; end
    endcase
    exp_q.push_back(e);
    a_cyc = t;
  endtask

  task automatic wait_rsp(output int r_cyc);
    r_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        r_cyc = t;
        return;
      end
    end
    check("rsp_seen", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_seen", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_en = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    done_force = 1'b0; e_hang = 1'b0; mdl_mode = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mdl_last = 1'b1;
  endtask

  // Scoreboard monitor: every completed response handshake pops one expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && clk_en && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
        if (exp_q.size() == 0) begin
          check("rsp_expected", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_both_valid", 32'(rsp0_valid & rsp1_valid), 32'd0);
          check("rsp_port", 32'(rsp1_valid), 32'(e.port));
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin : stim
    int          a, r, a_prev, n_abort, abort_t, n_stray;
    logic [31:0] ang;
    logic [1:0]  v;
    reset = 1'b1; clk_en = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_angle = '0; req1_angle = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    done_force = 1'b0; e_hang = 1'b0; force_res = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_abort", 32'(eng_abort), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_eng_dataa", eng_dataa, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single request on port 0, angle 0
    req0_angle = 32'd0; req0_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    accept(a);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("t1_eng_start", 32'(eng_start), 32'd1);
    check("t1_eng_dataa", eng_dataa, 32'd0);
    @(negedge clk);
    check("t1_start_pulse", 32'(eng_start), 32'd0);
    wait_rsp(r);
    check("t1_latency", 32'(r - a), 32'd19);
    check("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
    wait_idle();

    // Tie with continuous requests: grants alternate 0,1,0,1 back to back
    do_reset();
    req0_angle = 32'h11111111; req1_angle = 32'h22222222;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    a_prev = -1;
    for (int k = 0; k < 4; k++) begin
      accept(a);
      if (k > 0) check("t2_period", 32'(a - a_prev), 32'd20);
      a_prev = a;
      @(negedge clk);
      check("t2_eng_dataa", eng_dataa, (k % 2 == 1) ? 32'h22222222 : 32'h11111111);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Response backpressure on port 1 with port 0 waiting
    do_reset();
    ang = $urandom;
    req1_angle = ang; req1_valid = 1'b1; rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    accept(a);
    @(posedge clk); #1 req1_valid = 1'b0; req0_valid = 1'b1; req0_angle = $urandom;
    wait_rsp(r);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      check("t3_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("t3_rsp_data", rsp_data, eng_fn(ang));
      check("t3_req0_ready", 32'(req0_ready), 32'd0);
    end
    @(posedge clk); #1 rsp1_ready = 1'b1;
    accept(a);
    check("t3_idle_after_ready", 32'(a - r), 32'd11);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_idle();

    // Timeout: engine never completes; stray ready on port 1 must be ignored
    do_reset();
    e_hang = 1'b1; mdl_mode = 1;
    req0_angle = $urandom; req0_valid = 1'b1; rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    accept(a);
    @(posedge clk); #1 req0_valid = 1'b0;
    n_abort = 0; abort_t = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (eng_abort) begin
        n_abort++;
        if (abort_t < 0) abort_t = t;
      end
      if (rsp0_valid) break;
    end
    check("t4_abort_count", 32'(n_abort), 32'd1);
    check("t4_abort_cycle", 32'(abort_t - a), 32'd66);
    check("t4_rsp_err", 32'(rsp_err), 32'd1);
    check("t4_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_hold_resp", 32'(rsp0_valid), 32'd1);
    check("t4_abort_once", 32'(eng_abort), 32'd0);
    @(posedge clk); #1 rsp0_ready = 1'b1;
    wait_idle();
    e_hang = 1'b0; mdl_mode = 0;

    // Stale done in IDLE and first BUSY cycle is ignored
    do_reset();
    rsp0_ready = 1'b1; done_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_stray_idle", 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(posedge clk); #1;
    req0_angle = $urandom; req0_valid = 1'b1;
    accept(a);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 done_force = 1'b0;
    @(negedge clk);
    check("t5_no_early", 32'(rsp0_valid), 32'd0);
    wait_rsp(r);
    check("t5_latency", 32'(r - a), 32'd19);
    wait_idle();
    // Done in the second BUSY cycle is captured
    mdl_mode = 2;
    req0_angle = $urandom; req0_valid = 1'b1;
    accept(a);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 done_force = 1'b1;
    @(posedge clk); #1 done_force = 1'b0;
    wait_rsp(r);
    check("t5_second_busy", 32'(r - a), 32'd4);
    wait_idle();
    mdl_mode = 0;

    // Asynchronous reset mid-job
    do_reset();
    req0_angle = 32'hA5A5F00D; req0_valid = 1'b1; rsp0_ready = 1'b1;
    accept(a);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_eng_dataa", eng_dataa, 32'd0);
    check("t6_eng_start", 32'(eng_start), 32'd0);
    check("t6_eng_abort", 32'(eng_abort), 32'd0);
    check("t6_rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete(); mdl_last = 1'b1;
    n_stray = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) n_stray++;
    end
    check("t6_job_lost", 32'(n_stray), 32'd0);
    @(posedge clk); #1;

    // clk_en low for 5 cycles during BUSY stretches latency by 5
    req0_angle = $urandom; req0_valid = 1'b1;
    accept(a);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 clk_en = 1'b1;
    wait_rsp(r);
    check("t7_gated_latency", 32'(r - a), 32'd24);
    wait_idle();

    // Randomized requests and response backpressure
    do_reset();
    for (int j = 0; j < 8; j++) begin
      v = 2'($urandom_range(1, 3));
      req0_angle = $urandom; req1_angle = $urandom;
      req0_valid = v[0]; req1_valid = v[1];
      accept(a);
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 300; c++) begin
        rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
        @(negedge clk);
        if (!busy) break;
        @(posedge clk); #1;
      end
      check("rnd_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one iterative CORDIC cosine engine between two requesters, e.g. the Nios custom-instruction path and a hardware stream source. Requesters present a 32-bit fixed-point angle. The arbiter grants one request at a time using round-robin, starts the engine, and waits for completion. It returns the result to the granted requester, or an error if the engine times out. It sits between the requester ports and the single `cordic` engine instance.

## Interface
- `TIMEOUT`, default 64: number of BUSY cycles without `eng_done` before the job is aborted. The valid range is 20..255.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  all state advances only when high. When low, all registers hold.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_angle`, `req1_angle`  in  32  angle in the engine's fixed-point format.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle if valid is also high.
- `rsp0_valid`, `rsp1_valid`  out  1  response available.
- `rsp0_ready`, `rsp1_ready`  in  1  requester consumes the response.
- `rsp_data`  out  32  result word. Shared by both response ports and meaningful only with a `rspN_valid`.
- `rsp_err`  out  1  result is due to timeout. Qualified by `rspN_valid`.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_dataa`  out  32  angle to the engine. Held stable from ISSUE until leaving BUSY.
- `eng_abort`  out  1  one-cycle pulse. The integrator ORs it into the engine's reset.
- `eng_result`  in  32  engine result.
- `eng_done`  in  1  engine completion flag.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP. Reset puts the FSM in IDLE.
- **IDLE**
  - Arbitration is combinational.
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the requester other than `last_grant` wins.
  - The winner's `reqN_ready` is 1 and the other is 0. If neither is valid, both are 0.
  - On valid&ready, latch the angle into `eng_dataa`, store the winner index in `grant` and `last_grant`, and go to ISSUE.
- **ISSUE**
  - `eng_start` = 1 for exactly this cycle.
  - Clear the timeout counter and go to BUSY.
- **BUSY**
  - `eng_done` is ignored in the first BUSY cycle, because the engine flag may be stale.
  - From the second BUSY cycle on, when `eng_done` = 1: capture `eng_result` into `rsp_data`, set `rsp_err` = 0, and go to RESP.
  - The counter increments every BUSY cycle.
  - When the counter reaches `TIMEOUT` with no done:
    - set `rsp_data` = 0 and `rsp_err` = 1;
    - pulse `eng_abort` for one cycle;
    - go to RESP.
- **RESP**
  - `rsp[grant]_valid` = 1. The other response port's valid stays 0.
  - Hold the state until `rsp[grant]_ready` = 1, then go to IDLE.
  - A `rspN_ready` on the non-granted port is ignored.
- Only one job is outstanding at a time. Both `reqN_ready` are 0 outside IDLE.
- `last_grant` toggles only on acceptance. Its reset value is 1, so requester 0 wins the first tie.
- Request inputs are sampled only at acceptance. Later changes to the angle do not affect `eng_dataa`.
- `eng_done` seen in IDLE, ISSUE or RESP is ignored.

## Timing
- Reset values:
  - all `reqN_ready`, `rspN_valid`, `eng_start`, `eng_abort` and `rsp_err` are 0;
  - `rsp_data` and `eng_dataa` are 0;
  - `busy` is 0.
- Asynchronous reset mid-job returns to IDLE immediately.
  - No `eng_abort` is issued; the engine shares the system reset.
  - Any pending response is lost.
- Request handshake: accept in cycle A. `eng_start` is high in A+1. The first possible done capture is in A+3.
- With a 16-stage engine asserting done 17 cycles after its start cycle, `rspN_valid` first rises at A+19.
- Response handshake: if `rspN_ready` is high in the first RESP cycle, the FSM is IDLE on the next cycle. A new acceptance can then happen in that cycle, giving back-to-back throughput of one job per latency + 1 cycles.
- Timeout case: `eng_abort` is high in the BUSY cycle where the counter reaches `TIMEOUT`, together with the transition to RESP.
- `clk_en` low freezes everything, including the timeout counter.
  - Outputs hold their values, and `eng_start` is held if it was asserted.
  - The engine is on the same `clk_en`, so it is frozen with the arbiter.

## Test plan
- **Single request, requester 0:** reset, then `req0_valid` with angle 0x00000000. Expect:
  - `req0_ready` high in cycle A;
  - `eng_start` in A+1 with `eng_dataa` = 0;
  - engine model done at A+18;
  - `rsp0_valid` from A+19 with `rsp_data` = model result (≈0x26DD3B6A for this angle) and `rsp_err` = 0;
  - `rsp1_valid` = 0 throughout.
- **Tie and round-robin:** both requesters valid continuously with angles 0x11111111 and 0x22222222, responses always ready. Expect grants in the order 0, 1, 0, 1, with each `eng_dataa` matching the granted angle.
- **Response backpressure:** hold `rsp1_ready` = 0 for 10 cycles. Expect:
  - `rsp1_valid` and `rsp_data` stable for those cycles;
  - `req0_ready` = 0 throughout, even with `req0_valid` = 1;
  - IDLE reached one cycle after ready rises.
- **Timeout:** the engine model never asserts done, `TIMEOUT` = 64. Expect:
  - `eng_abort` pulses exactly once, 64 BUSY cycles after the first BUSY cycle;
  - then `rsp_err` = 1 and `rsp_data` = 0.
- **Stale done and stray done:** hold `eng_done` high in IDLE and during the first BUSY cycle. Expect no early completion; capture only from the second BUSY cycle on.
- **Reset mid-job and `clk_en` gating:** assert reset during BUSY, expecting all outputs at their reset values immediately. Separately, drop `clk_en` for 5 cycles during BUSY, expecting the response latency to stretch by exactly 5 cycles.
